// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- instruction fetch program counter with redirect buffering,
// terminal halt and saturating statistics counters.
//
// Parameters
//   RESET_PC        word-index fetch address loaded on reset
//   CNT_W           width of each statistics counter
//
// Ports
//   clk             single clock, all state updates on its rising edge
//   rst_n           asynchronous active-low reset
//   stall           hazard unit requests the PC be held
//   halt            terminal stop request (syscall/exit)
//   pc_bj           redirect request from the branch/jump target selector
//   redirect_target word-index redirect address, valid while pc_bj=1
//   pc              current fetch word address (registered)
//   pc_plus1        pc+1 modulo 2^32 (combinational)
//   flush_ifid      IF/ID bubble request in the cycle a redirect is applied
//   redirect_pending a redirect that arrived during a stall is buffered
//   halted          fetch permanently frozen until reset
//   bj_count        number of applied redirects (saturating)
//   stall_count     number of stalled, non-halted cycles (saturating)
// ---------------------------------------------------------------------------
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             halt,
   input  logic             pc_bj,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus1,
   output logic             flush_ifid,
   output logic             redirect_pending,
   output logic             halted,
   output logic [CNT_W-1:0] bj_count,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [31:0]      pc_next;
   logic [31:0]      target_buf;
   logic [31:0]      target_buf_next;
   logic             pending_next;
   logic [CNT_W-1:0] bj_count_next;
   logic [CNT_W-1:0] stall_count_next;

   logic stop;
   logic live_redirect;
   logic buffered_redirect;
   logic capture;

   assign halted   = (state == ST_HALTED);
   assign pc_plus1 = pc + 32'd1;

   // Request decode in priority order. A live redirect only exists when not
   // stalled; the buffered one only fires once nothing live competes with it,
   // which on an unstalled cycle means pc_bj is low.
   always_comb begin
      stop              = halt | halted;
      live_redirect     = ~stop & pc_bj & ~stall;
      buffered_redirect = ~stop & redirect_pending & ~stall & ~pc_bj;
      capture           = ~stop & pc_bj & stall;
   end

   // The bubble request is purely combinational; it is gated by rst_n so a
   // stray pc_bj during reset cannot produce a flush.
   assign flush_ifid = rst_n & (live_redirect | buffered_redirect);

   // Next-state and next-value logic. Defaults hold everything, then each
   // priority branch overrides only what it changes.
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      target_buf_next  = target_buf;
      pending_next     = redirect_pending;
      bj_count_next    = bj_count;
      stall_count_next = stall_count;

      if (stop) begin
         state_next   = ST_HALTED;
         pending_next = 1'b0;
      end else if (live_redirect) begin
         pc_next      = redirect_target;
         pending_next = 1'b0;
      end else if (buffered_redirect) begin
         pc_next      = target_buf;
         pending_next = 1'b0;
      end else if (stall) begin
         if (capture) begin
            target_buf_next = redirect_target;
            pending_next    = 1'b1;
         end
      end else begin
         pc_next = pc_plus1;
      end

      if ((live_redirect | buffered_redirect) && (bj_count != {CNT_W{1'b1}})) begin
         bj_count_next = bj_count + CNT_W'(1);
      end

      if (stall && !stop && (stall_count != {CNT_W{1'b1}})) begin
         stall_count_next = stall_count + CNT_W'(1);
      end
   end

   // State register; reset discards any in-flight redirect or halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_RUN;
         pc               <= RESET_PC;
         target_buf       <= 32'd0;
         redirect_pending <= 1'b0;
         bj_count         <= '0;
         stall_count      <= '0;
      end else begin
         state            <= state_next;
         pc               <= pc_next;
         target_buf       <= target_buf_next;
         redirect_pending <= pending_next;
         bj_count         <= bj_count_next;
         stall_count      <= stall_count_next;
      end
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: word-index fetch address loaded on reset.
REQ-002 SHALL provide parameter CNT_W, default 32: width of each statistics counter.
REQ-003 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide port stall, input, 1: hazard unit requests PC hold.
REQ-006 SHALL provide port halt, input, 1: terminal stop request (syscall/exit).
REQ-007 SHALL provide port pc_bj, input, 1: redirect request from the branch/jump target selector.
REQ-008 SHALL provide port redirect_target, input, 32: word-index redirect address; valid only while pc_bj=1.
REQ-009 SHALL provide port pc, output, 32: current fetch word address (registered).
REQ-010 SHALL provide port pc_plus1, output, 32: pc+1 modulo 2^32 (combinational from pc).
REQ-011 SHALL provide port flush_ifid, output, 1: bubble request for IF/ID, asserted in the cycle a redirect is applied.
REQ-012 SHALL provide port redirect_pending, output, 1: a deferred redirect is buffered.
REQ-013 SHALL provide port halted, output, 1: fetch permanently frozen.
REQ-014 SHALL provide port bj_count, output, CNT_W: number of applied redirects.
REQ-015 SHALL provide port stall_count, output, CNT_W: number of stalled cycles.

Function
REQ-016 SHALL evaluate next-PC with fixed priority each cycle: halted/halt > live redirect (pc_bj & ~stall) > pending redirect (redirect_pending & ~stall) > stall hold > increment.
REQ-017 SHALL load pc <= pc+1 (32-bit wrap, 32'hFFFF_FFFF -> 0) when no higher-priority condition holds.
REQ-018 SHALL load pc <= redirect_target on a live redirect; drive flush_ifid=1 in that same cycle; clear any pending buffer at that edge (live target wins over buffered).
REQ-019 SHALL, when pc_bj=1 and stall=1, hold pc, capture redirect_target into a one-entry buffer, and set redirect_pending=1 at the next edge; a later pc_bj while still stalled SHALL overwrite the buffer (newest wins).
REQ-020 SHALL, on the first cycle with stall=0 and redirect_pending=1 and pc_bj=0, load pc from the buffer, drive flush_ifid=1, and clear redirect_pending at that edge.
REQ-021 SHALL keep flush_ifid combinational and asserted for exactly one cycle per applied redirect; 0 in all other cycles.
REQ-022 SHALL, on halt=1 in any cycle, hold pc, set halted=1 at the next edge, and from then on ignore stall, pc_bj and pending state; flush_ifid=0 while halt or halted.
REQ-023 SHALL clear redirect_pending when entering halted.
REQ-024 SHALL increment bj_count by 1 per applied redirect (live or buffered), saturating at all-ones.
REQ-025 SHALL increment stall_count by 1 per cycle with stall=1 and halted=0 and halt=0, saturating at all-ones.
REQ-026 SHALL treat a buffer capture as not an applied redirect (counted only when loaded into pc).

Reset
REQ-027 SHALL, on rst_n=0, immediately force pc=RESET_PC, redirect_pending=0, halted=0, bj_count=0, stall_count=0, buffer=0, independent of clk.
REQ-028 SHALL drive flush_ifid=0 while rst_n=0, and pc_plus1=RESET_PC+1.
REQ-029 SHALL discard any in-flight redirect or halt on reset assertion mid-operation; first edge after release with no requests gives pc=RESET_PC+1.

Verification
REQ-030 SHALL verify: release reset, idle 4 cycles -> pc 0,1,2,3,4; flush_ifid never 1; counters 0.
REQ-031 SHALL verify: at pc=5, pc_bj=1, target=32'h40 -> flush_ifid=1 that cycle, next pc=32'h40, then 32'h41; bj_count=1.
REQ-032 SHALL verify: at pc=8, stall=1 for 3 cycles with pc_bj=1 target 32'h20 in cycle 1 and 32'h30 in cycle 2 -> pc holds 8, redirect_pending=1, stall_count=3; first unstalled cycle flush_ifid=1, pc->32'h30, pending cleared, bj_count=1.
REQ-033 SHALL verify: pending target 32'h30 and, on unstall cycle, live pc_bj target 32'h50 -> pc=32'h50, pending cleared, bj_count increments by 1 only.
REQ-034 SHALL verify: halt=1 at pc=12 with simultaneous pc_bj -> pc stays 12, halted=1, flush_ifid=0; further stall/pc_bj do nothing; rst_n low async -> pc=0, halted=0.
REQ-035 SHALL verify: RESET_PC=32'hFFFF_FFFE, CNT_W=2 -> pc wraps FFFF_FFFF -> 0; 5 stalled cycles leave stall_count=3 (saturated).
